// File: rtl/apb_pkg.sv
// Shared defaults and FSM state encoding for the APB slave controller.
package apb_pkg;
    localparam int APB_ADDR_WIDTH  = 32;
    localparam int APB_DATA_WIDTH  = 32;
    localparam int APB_MEM_DEPTH   = 256;
    localparam int APB_WAIT_STATES = 0;
    localparam int CNT_W           = 3;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        MEMWAIT,
        WAITST,
        RESP,
        ERR
    } apb_state_t;
endpackage

// File: rtl/apb_wait_cnt.sv
// Wait-state counter: counts while start is held, done on the last wait cycle.
module apb_wait_cnt
    import apb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);
    logic [CNT_W-1:0] cnt;

    // Cleared whenever the FSM is outside WAITST, so each transfer starts at 0.
    always_ff @(posedge clk) begin
        if (!rst_n || !start) cnt <= '0;
        else                  cnt <= cnt + CNT_W'(1);
    end

    assign done = start && (cnt == limit - CNT_W'(1));
endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave bridging single transfers onto a simple synchronous memory port.
module apb_slave_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int STRB_SIZE   = DATA_WIDTH / 8,
    parameter int MEM_DEPTH   = APB_MEM_DEPTH,
    parameter int WAIT_STATES = APB_WAIT_STATES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_SIZE-1:0]  pstrb,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [STRB_SIZE-1:0]  mem_be,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);
    localparam logic NO_WAIT = (WAIT_STATES == 0);

    apb_state_t            state;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_SIZE-1:0]  pstrb_q;
    logic                  pwrite_q;
    logic                  wait_done;
    logic                  setup_err;
    logic                  in_access;

    assign setup_err = (paddr >= ADDR_WIDTH'(MEM_DEPTH)) || (pwrite && (pstrb == '0));
    assign in_access = (state == ACCESS);

    // Memory strobes are decoded from the registered state, so they last exactly one cycle.
    assign mem_wr      = in_access &&  pwrite_q;
    assign mem_rd      = in_access && !pwrite_q;
    assign mem_be      = !in_access ? '0 : (pwrite_q ? pstrb_q : '1);
    assign mem_address = in_access ? paddr_q  : '0;
    assign mem_data_in = in_access ? pwdata_q : '0;

    apb_wait_cnt u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (state == WAITST),
        .limit (CNT_W'(WAIT_STATES)),
        .done  (wait_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pwrite_q <= 1'b0;
            prdata   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        paddr_q  <= paddr;
                        pwdata_q <= pwdata;
                        pstrb_q  <= pstrb;
                        pwrite_q <= pwrite;
                        if (setup_err) begin
                            state   <= ERR;
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                            if (!pwrite) prdata <= '0;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel)          state <= IDLE;
                    else if (!pwrite_q) state <= MEMWAIT;
                    else if (NO_WAIT) begin
                        state  <= RESP;
                        pready <= 1'b1;
                    end else            state <= WAITST;
                end
                MEMWAIT: begin
                    if (!psel) state <= IDLE;
                    else begin
                        prdata <= mem_data_out;
                        if (NO_WAIT) begin
                            state  <= RESP;
                            pready <= 1'b1;
                        end else state <= WAITST;
                    end
                end
                WAITST: begin
                    if (!psel) state <= IDLE;
                    else if (wait_done) begin
                        state  <= RESP;
                        pready <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed bench: default-timing DUT with a memory model, plus a 3-wait-state DUT.
module tb_apb_slave_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel0, psel1, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;

    logic [31:0] prdata0, prdata1, maddr0, maddr1, mdin0, mdin1;
    logic [31:0] mdo0, mdo1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic        mwr0, mwr1, mrd0, mrd1;
    logic [3:0]  mbe0, mbe1;

    logic [31:0] mem [0:255];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    apb_slave_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
        .pready(pready0), .pslverr(pslverr0), .mem_wr(mwr0), .mem_rd(mrd0),
        .mem_be(mbe0), .mem_address(maddr0), .mem_data_in(mdin0), .mem_data_out(mdo0)
    );

    apb_slave_ctrl #(.WAIT_STATES(3)) u_dut_ws (
        .clk(clk), .rst_n(rst_n), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata1),
        .pready(pready1), .pslverr(pslverr1), .mem_wr(mwr1), .mem_rd(mrd1),
        .mem_be(mbe1), .mem_address(maddr1), .mem_data_in(mdin1), .mem_data_out(mdo1)
    );

    // Byte-enabled memory with one-cycle read latency
    always @(posedge clk) begin
        if (mwr0)
            for (int b = 0; b < 4; b++)
                if (mbe0[b]) mem[maddr0[7:0]][b*8 +: 8] <= mdin0[b*8 +: 8];
        if (mrd0) mdo0 <= mem[maddr0[7:0]];
        if (mrd1) mdo1 <= 32'hCAFE0000 | maddr1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer; lat counts cycles from the setup edge to pready (0 = timed out).
    task automatic apb_xfer(input bit ws, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            output int lat, output logic [31:0] rd, output logic err,
                            output int nwr, output int nrd, output logic [31:0] waddr,
                            output logic [3:0] wbe, output int both);
        lat = 0; rd = '0; err = 1'b0; nwr = 0; nrd = 0; waddr = '0; wbe = '0; both = 0;
        if (ws) psel1 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        tick();
        penable = 1'b1;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (ws ? mwr1 : mwr0) begin nwr++; waddr = ws ? maddr1 : maddr0; wbe = ws ? mbe1 : mbe0; end
            if (ws ? mrd1 : mrd0) nrd++;
            if ((ws ? mwr1 : mwr0) && (ws ? mrd1 : mrd0)) both++;
            if (ws ? pready1 : pready0) begin
                lat = k;
                rd  = ws ? prdata1 : prdata0;
                err = ws ? pslverr1 : pslverr0;
            end else tick();
        end
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        tick();
    endtask

    int          lat, nwr, nrd, both, tot_wr, be_bad;
    logic [31:0] rd, waddr;
    logic [3:0]  wbe;
    logic        err;

    initial begin
        rst_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        tick(); tick();
        chk("rst_pready", {31'd0, pready0}, 32'd0);
        chk("rst_prdata", prdata0, 32'd0);
        chk("rst_strobes", {30'd0, mwr0, mrd0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Write 0xF0
        apb_xfer(0, 1, 32'hF0, 32'h000A3210, 4'hF, lat, rd, err, nwr, nrd, waddr, wbe, both);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_nwr", 32'(nwr), 32'd1);
        chk("wr_be", {28'd0, wbe}, 32'hF);
        chk("wr_addr", waddr, 32'hF0);
        chk("wr_err", {31'd0, err}, 32'd0);

        // Read 0xF0 back
        apb_xfer(0, 0, 32'hF0, 32'h0, 4'h0, lat, rd, err, nwr, nrd, waddr, wbe, both);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_nrd", 32'(nrd), 32'd1);
        chk("rd_data", rd, 32'h000A3210);
        chk("rd_err", {31'd0, err}, 32'd0);

        // prdata holds across a write
        apb_xfer(0, 1, 32'h10, 32'h12345678, 4'hF, lat, rd, err, nwr, nrd, waddr, wbe, both);
        chk("hold_prdata", prdata0, 32'h000A3210);

        // Errors: address out of range, zero strobes, bad read clears prdata
        apb_xfer(0, 1, 32'h100, 32'h1, 4'hF, lat, rd, err, nwr, nrd, waddr, wbe, both);
        chk("err_addr_lat", 32'(lat), 32'd1);
        chk("err_addr_slverr", {31'd0, err}, 32'd1);
        chk("err_addr_nwr", 32'(nwr), 32'd0);
        apb_xfer(0, 1, 32'h10, 32'h1, 4'h0, lat, rd, err, nwr, nrd, waddr, wbe, both);
        chk("err_strb_lat", 32'(lat), 32'd1);
        chk("err_strb_slverr", {31'd0, err}, 32'd1);
        chk("err_strb_nwr", 32'(nwr), 32'd0);
        apb_xfer(0, 0, 32'h100, 32'h0, 4'h0, lat, rd, err, nwr, nrd, waddr, wbe, both);
        chk("err_rd_slverr", {31'd0, err}, 32'd1);
        chk("err_rd_prdata", rd, 32'd0);
        chk("err_rd_nrd", 32'(nrd), 32'd0);

        // Three wait states on the second instance
        apb_xfer(1, 0, 32'h12, 32'h0, 4'h0, lat, rd, err, nwr, nrd, waddr, wbe, both);
        chk("ws_lat", 32'(lat), 32'd6);
        chk("ws_data", rd, 32'hCAFE0012);
        chk("ws_nrd", 32'(nrd), 32'd1);

        // Reset during ACCESS of a read
        apb_xfer(0, 0, 32'hF0, 32'h0, 4'h0, lat, rd, err, nwr, nrd, waddr, wbe, both);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hF0;
        tick();
        penable = 1'b1;
        chk("rstmid_rd_issued", {31'd0, mrd0}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rstmid_outs", {29'd0, mrd0, pready0, pslverr0}, 32'd0);
        chk("rstmid_prdata", prdata0, 32'd0);
        chk("rstmid_addr", maddr0, 32'd0);
        rst_n = 1'b1; psel0 = 1'b0; penable = 1'b0;
        tick();
        chk("rstmid_after", {30'd0, mrd0, pready0}, 32'd0);

        // psel dropped after ACCESS: no pready, no further strobe
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h9; pstrb = 4'hF;
        tick();
        penable = 1'b1;
        chk("drop_wr_issued", {31'd0, mwr0}, 32'd1);
        psel0 = 1'b0; penable = 1'b0;
        tick();
        chk("drop_idle1", {30'd0, mwr0, pready0}, 32'd0);
        tick();
        chk("drop_idle2", {30'd0, mwr0, pready0}, 32'd0);

        // Back-to-back byte writes over 0x3D..0x46
        apb_xfer(0, 1, 32'h40, 32'hFFFFFFFF, 4'hF, lat, rd, err, nwr, nrd, waddr, wbe, both);
        tot_wr = 0; be_bad = 0;
        for (int i = 0; i < 10; i++) begin
            apb_xfer(0, 1, 32'h3D + i, 32'h55000000 | i, 4'h1, lat, rd, err, nwr, nrd, waddr, wbe, both);
            tot_wr += nwr;
            if (wbe != 4'h1 || both != 0) be_bad++;
            chk($sformatf("b2b_addr%0d", i), waddr, 32'h3D + i);
        end
        chk("b2b_pulses", 32'(tot_wr), 32'd10);
        chk("b2b_be", 32'(be_bad), 32'd0);
        apb_xfer(0, 0, 32'h40, 32'h0, 4'h0, lat, rd, err, nwr, nrd, waddr, wbe, both);
        chk("b2b_readback", rd, 32'hFFFFFF03);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
